jk_seq_driver: RTL

Closed-loop stimulus driver for a bank of W external JK flip-flops of the 74HC112 kind. It stores a programmed target-state sequence and drives J/K each cycle using the JK excitation table, so the bank steps through that sequence. It reads the bank's Q back and, when compiled in, checks every step. It sits at the J/K input side of a flip-flop bank, on the same clock.

---
 rtl/jk_drv_pkg.sv | 31 +++
 rtl/jk_excite_cell.sv | 14 +
 rtl/jk_seq_driver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and JK excitation helper for the JK sequence driver.
package jk_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LAST,
    DONE,
    ERR
  } state_t;

  localparam logic JK_DC = 1'b0;

  // Returns {J, K} needed to move q to t on the next edge.
  function automatic logic [1:0] jk_excite(
    input logic q,
    input logic t
  );
    logic [1:0] jk;
    jk = 2'b00;
    unique case ({q, t})
      2'b00: jk = {1'b0, JK_DC};
      2'b01: jk = {1'b1, JK_DC};
      2'b10: jk = {JK_DC, 1'b1};
      2'b11: jk = {JK_DC, 1'b0};
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// One-bit JK excitation cell; outputs hold (J=K=0) when not enabled.
module jk_excite_cell
  import jk_drv_pkg::*;
(
  input  logic q,
  input  logic t,
  input  logic en,
  output logic j,
  output logic k
);

  assign {j, k} = en ? jk_excite(q, t) : 2'b00;

endmodule

// File: rtl/jk_seq_driver.sv
// Closed-loop JK flip-flop bank sequence driver.
// Step checking and Err reporting are built only with JKDRV_CHECK_EN.
module jk_seq_driver
  import jk_drv_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rd,
  input  logic          Wr_en,
  input  logic [AW-1:0] Wr_addr,
  input  logic [W-1:0]  Wr_data,
  input  logic          Start,
  input  logic [LW-1:0] Len,
  input  logic [W-1:0]  Q_fb,
  output logic [W-1:0]  J,
  output logic [W-1:0]  K,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic [AW-1:0] Err_idx
);

  logic [W-1:0]  mem [DEPTH];
  state_t        state;
  logic [AW-1:0] idx;
  logic [LW-1:0] len_q;
  logic          done_q;
  logic          drive_en;
  logic          idle_like;
  logic          start_ok;
  logic          fail_now;
  logic [W-1:0]  tgt;
  logic [LW-1:0] len_sat;
  logic [LW-1:0] idx_nx;

  assign drive_en  = (state == RUN) || (state == LAST);
  assign idle_like = (state == IDLE) || (state == DONE)
                  || (state == ERR);
  assign start_ok  = Start && idle_like;
  assign tgt       = mem[idx];
  assign len_sat   = (Len > LW'(DEPTH)) ? LW'(DEPTH) : Len;
  assign idx_nx    = LW'(idx) + LW'(1);
  assign Busy      = drive_en;
  assign Done      = done_q && !fail_now;

  always_ff @(posedge Clk) begin
    if (Wr_en && idle_like) begin
      mem[Wr_addr] <= Wr_data;
    end
  end

  for (genvar b = 0; b < W; b++) begin : g_cell
    jk_excite_cell u_cell (
      .q  (Q_fb[b]),
      .t  (tgt[b]),
      .en (drive_en),
      .j  (J[b]),
      .k  (K[b])
    );
  end

  always_ff @(posedge Clk) begin
    if (Rd) begin
      state  <= IDLE;
      idx    <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          // A late mismatch on the final step beats completion.
          if (state == DONE && fail_now) begin
            state <= ERR;
          end else if (Start) begin
            len_q <= len_sat;
            idx   <= '0;
            if (len_sat == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (len_sat == LW'(1)) begin
              state <= LAST;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (fail_now) begin
            state <= ERR;
          end else begin
            idx <= idx + AW'(1);
            if (idx_nx == len_q - LW'(1)) begin
              state <= LAST;
            end
          end
        end
        LAST: begin
          if (fail_now) begin
            state <= ERR;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JKDRV_CHECK_EN
  logic [W-1:0]  exp_q;
  logic          chk_q;
  logic [AW-1:0] chk_idx;
  logic          err_q;
  logic [AW-1:0] err_idx_q;

  assign fail_now = chk_q && !err_q && (Q_fb != exp_q);
  assign Err      = err_q || fail_now;
  assign Err_idx  = err_q    ? err_idx_q :
                    fail_now ? chk_idx   : '0;

  always_ff @(posedge Clk) begin
    if (Rd) begin
      chk_q     <= 1'b0;
      exp_q     <= '0;
      chk_idx   <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      chk_q <= drive_en && !fail_now;
      if (drive_en) begin
        exp_q   <= tgt;
        chk_idx <= idx;
      end
      if (fail_now) begin
        err_q     <= 1'b1;
        err_idx_q <= chk_idx;
      end else if (start_ok) begin
        err_q     <= 1'b0;
        err_idx_q <= '0;
      end
    end
  end
`else
  assign fail_now = 1'b0;
  assign Err      = 1'b0;
  assign Err_idx  = '0;
`endif

endmodule
